// File: rtl/ipf_fetch_ctrl.sv
// Instruction-fetch request controller: one outstanding request, delayed-branch PC sequencing, flush/discard handling.
// Optional macro IPF_ADEL_CHECK_EN adds an AdEL fetch exception for misaligned PCs.
module ipf_fetch_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        id_is_branch,
  input  logic [7:0]  asid_in,
  input  logic        tlb_miss,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  output logic [31:0] PC_plus4,
  output logic        is_delayslot,
  output logic [31:0] if_fetch_exc_type,
  output logic [7:0]  asid,
  output logic        instMiss,
  output logic        instValid,
  output logic        ipf_stall
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DISCARD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] bt_q, bt_d;
  logic        bp_q, bp_d;
  logic        arm_q, arm_d;
  logic        ds_q, ds_d;
  logic [7:0]  asid_q, asid_d;
  logic        miss_q, miss_d;
  logic        adel_q, adel_d;
  logic        halt_q, halt_d;

  logic        accept;
  logic        done;
  logic        exc;
  logic        valid;
  logic        req;
  logic        load_pc;
  logic [31:0] pc_nx;
  logic [31:0] pc_seq;
  logic [31:0] pc_adv;

  assign accept = (state_q == S_REQ) && !adel_q && inst_addr_ok;
  assign pc_seq = pc_q + 32'd4;
  // Target is used only once the delay-slot fetch (arm_q) has been issued.
  assign pc_adv = (bp_q && arm_q) ? bt_q : pc_seq;

  always_comb begin
    state_d = state_q;
    bt_d    = bt_q;
    bp_d    = bp_q;
    arm_d   = arm_q;
    ds_d    = ds_q;
    asid_d  = asid_q;
    miss_d  = miss_q;
    halt_d  = halt_q;
    done    = 1'b0;
    exc     = 1'b0;
    valid   = 1'b0;
    req     = 1'b0;
    load_pc = 1'b0;
    pc_nx   = pc_q;

    case (state_q)
      S_IDLE: begin
        if (!halt_q && !stall) state_d = S_REQ;
      end
      S_REQ: begin
        if (adel_q) begin
          done = 1'b1;
          exc  = 1'b1;
        end else begin
          req = 1'b1;
          if (inst_addr_ok) begin
            asid_d = asid_in;
            miss_d = tlb_miss;
            if (inst_data_ok) begin
              done = 1'b1;
              exc  = tlb_miss;
            end else begin
              state_d = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          done = 1'b1;
          exc  = miss_q;
        end
      end
      S_DISCARD: begin
        if (inst_data_ok) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      pc_nx   = flush_pc;
      load_pc = 1'b1;
      bp_d    = 1'b0;
      arm_d   = 1'b0;
      ds_d    = 1'b0;
      halt_d  = 1'b0;
      miss_d  = 1'b0;
      // A request already accepted still owes one data beat that must be dropped.
      if (((state_q == S_WAIT || state_q == S_DISCARD) || accept) && !inst_data_ok)
        state_d = S_DISCARD;
      else
        state_d = S_REQ;
    end else if (done) begin
      valid = 1'b1;
      ds_d  = id_is_branch;
      if (exc) begin
        halt_d  = 1'b1;
        state_d = S_IDLE;
      end else begin
        pc_nx   = pc_adv;
        load_pc = 1'b1;
        if (bp_q && arm_q) begin
          bp_d  = 1'b0;
          arm_d = 1'b0;
        end else if (bp_q) begin
          arm_d = 1'b1;
        end
        state_d = stall ? S_IDLE : S_REQ;
      end
    end

    if (br_taken && !flush) begin
      bp_d  = 1'b1;
      bt_d  = br_target;
      arm_d = done;
    end
  end

  assign pc_d = pc_nx;

`ifdef IPF_ADEL_CHECK_EN
  assign adel_d = load_pc ? (pc_nx[1:0] != 2'b00) : adel_q;
`else
  assign adel_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= 32'hBFC0_0000;
      bt_q    <= 32'd0;
      bp_q    <= 1'b0;
      arm_q   <= 1'b0;
      ds_q    <= 1'b0;
      asid_q  <= 8'd0;
      miss_q  <= 1'b0;
      adel_q  <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      bt_q    <= bt_d;
      bp_q    <= bp_d;
      arm_q   <= arm_d;
      ds_q    <= ds_d;
      asid_q  <= asid_d;
      miss_q  <= miss_d;
      adel_q  <= adel_d;
      halt_q  <= halt_d;
    end
  end

  assign inst_req          = req;
  assign inst_addr         = pc_q;
  assign PC_plus4          = pc_seq;
  assign is_delayslot      = ds_q;
  assign asid              = accept ? asid_in : asid_q;
  assign instMiss          = accept ? tlb_miss : miss_q;
  assign if_fetch_exc_type = {30'd0, instMiss, adel_q};
  assign instValid         = valid;
  assign ipf_stall         = (state_q != S_IDLE) && !valid;

endmodule

// File: tb/tb_ipf_fetch_ctrl.sv
// Directed bench for ipf_fetch_ctrl: cycle table for sequencing/flush/reset, hand sequences for handshake hold and exceptions.
module tb_ipf_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, br_taken, id_is_branch, tlb_miss;
  logic [31:0] flush_pc, br_target;
  logic [7:0]  asid_in;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, PC_plus4, if_fetch_exc_type;
  logic        is_delayslot, instMiss, instValid, ipf_stall;
  logic [7:0]  asid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ipf_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .br_taken(br_taken), .br_target(br_target), .id_is_branch(id_is_branch),
    .asid_in(asid_in), .tlb_miss(tlb_miss), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .PC_plus4(PC_plus4),
    .is_delayslot(is_delayslot), .if_fetch_exc_type(if_fetch_exc_type), .asid(asid),
    .instMiss(instMiss), .instValid(instValid), .ipf_stall(ipf_stall)
  );

  typedef struct {
    logic        rst_n, stall, flush, br_taken, id_br, aok, dok;
    logic [31:0] fpc, btgt;
    logic        e_req, e_valid, e_ds, e_stall;
    logic [31:0] e_addr;
  } vec_t;

  vec_t tbl[32];

  function automatic vec_t mk(input logic r, input logic st, input logic fl, input logic [31:0] fpc,
                              input logic brt, input logic [31:0] btgt, input logic idb,
                              input logic aok, input logic dok, input logic ereq,
                              input logic [31:0] eaddr, input logic evalid, input logic eds,
                              input logic estall);
    vec_t v;
    v.rst_n = r; v.stall = st; v.flush = fl; v.fpc = fpc; v.br_taken = brt; v.btgt = btgt;
    v.id_br = idb; v.aok = aok; v.dok = dok; v.e_req = ereq; v.e_addr = eaddr;
    v.e_valid = evalid; v.e_ds = eds; v.e_stall = estall;
    return v;
  endfunction

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic idle_inputs();
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0; flush_pc = 32'd0; br_taken = 1'b0;
    br_target = 32'd0; id_is_branch = 1'b0; tlb_miss = 1'b0; asid_in = 8'd0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic step();
    @(negedge clk);
    idle_inputs();
  endtask

  localparam logic [31:0] R = 32'hBFC0_0000;
  localparam logic [31:0] T = 32'h8000_1000;
  localparam logic [31:0] E = 32'hBFC0_0380;

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    // columns: rst stall flush fpc brt btgt idb aok dok | req addr valid ds stall
    tbl[0]  = mk(0,0,0,0,0,0,0,0,0, 0,R,0,0,0);
    tbl[1]  = mk(1,0,0,0,0,0,0,0,0, 0,R,0,0,0);
    tbl[2]  = mk(1,0,0,0,0,0,0,0,0, 1,R,0,0,1);
    tbl[3]  = mk(1,0,0,0,0,0,0,1,0, 1,R,0,0,1);
    tbl[4]  = mk(1,0,0,0,0,0,0,0,0, 0,R,0,0,1);
    tbl[5]  = mk(1,0,0,0,0,0,0,0,1, 0,R,1,0,0);
    tbl[6]  = mk(1,0,0,0,0,0,0,1,1, 1,32'hBFC0_0004,1,0,0);
    tbl[7]  = mk(1,0,0,0,1,T,0,1,0, 1,32'hBFC0_0008,0,0,1);
    tbl[8]  = mk(1,0,0,0,0,0,1,0,1, 0,32'hBFC0_0008,1,0,0);
    tbl[9]  = mk(1,0,0,0,0,0,0,1,1, 1,32'hBFC0_000C,1,1,0);
    tbl[10] = mk(1,0,0,0,0,0,0,0,0, 1,T,0,0,1);
    tbl[11] = mk(1,0,0,0,0,0,0,1,0, 1,T,0,0,1);
    tbl[12] = mk(1,1,0,0,0,0,0,0,1, 0,T,1,0,0);
    tbl[13] = mk(1,1,0,0,0,0,0,0,0, 0,32'h8000_1004,0,0,0);
    tbl[14] = mk(1,0,0,0,0,0,0,0,0, 0,32'h8000_1004,0,0,0);
    tbl[15] = mk(1,0,0,0,0,0,0,0,0, 1,32'h8000_1004,0,0,1);
    tbl[16] = mk(1,0,0,0,0,0,0,1,0, 1,32'h8000_1004,0,0,1);
    tbl[17] = mk(1,0,1,E,0,0,0,0,0, 0,32'h8000_1004,0,0,1);
    tbl[18] = mk(1,0,0,0,0,0,0,0,1, 0,E,0,0,1);
    tbl[19] = mk(1,0,0,0,0,0,0,0,0, 1,E,0,0,1);
    tbl[20] = mk(1,0,0,0,0,0,0,1,0, 1,E,0,0,1);
    tbl[21] = mk(1,0,1,32'h8000_0180,0,0,0,0,1, 0,E,0,0,1);
    tbl[22] = mk(1,0,0,0,0,0,0,0,0, 1,32'h8000_0180,0,0,1);
    tbl[23] = mk(1,0,1,32'h8000_0200,0,0,0,0,0, 1,32'h8000_0180,0,0,1);
    tbl[24] = mk(1,0,1,E,0,0,0,1,0, 1,32'h8000_0200,0,0,1);
    tbl[25] = mk(1,0,0,0,0,0,0,0,0, 0,E,0,0,1);
    tbl[26] = mk(1,0,0,0,0,0,0,0,1, 0,E,0,0,1);
    tbl[27] = mk(1,0,0,0,0,0,0,0,0, 1,E,0,0,1);
    tbl[28] = mk(1,0,0,0,0,0,0,1,0, 1,E,0,0,1);
    tbl[29] = mk(0,0,0,0,0,0,0,0,0, 0,E,0,0,1);
    tbl[30] = mk(1,0,0,0,0,0,0,0,1, 0,R,0,0,0);
    tbl[31] = mk(1,0,0,0,0,0,0,0,0, 1,R,0,0,1);

    // Reset values of the captured fields.
    repeat (2) @(negedge clk);
    #1;
    chk("reset_asid_miss_ds", {59'd0, asid, instMiss}, 68'd0);
    chk("reset_exc_type", {36'd0, if_fetch_exc_type}, 68'd0);
    chk("reset_pc4_valid", {35'd0, instValid, PC_plus4}, {35'd0, 1'b0, 32'hBFC0_0004});

    for (int i = 0; i < 32; i++) begin
      step();
      rst_n = tbl[i].rst_n; stall = tbl[i].stall; flush = tbl[i].flush; flush_pc = tbl[i].fpc;
      br_taken = tbl[i].br_taken; br_target = tbl[i].btgt; id_is_branch = tbl[i].id_br;
      inst_addr_ok = tbl[i].aok; inst_data_ok = tbl[i].dok;
      #1;
      chk($sformatf("vec%0d", i),
          {inst_req, instValid, is_delayslot, ipf_stall, inst_addr, PC_plus4},
          {tbl[i].e_req, tbl[i].e_valid, tbl[i].e_ds, tbl[i].e_stall, tbl[i].e_addr, tbl[i].e_addr + 32'd4});
    end

    // Address handshake held off for 5 cycles while the ASID changes.
    for (int i = 0; i < 5; i++) begin
      step();
      asid_in = 8'(i + 1);
      #1;
      chk($sformatf("hold%0d", i), {35'd0, inst_req, ipf_stall, inst_addr}, {35'd0, 1'b1, 1'b1, R});
    end
    step();
    inst_addr_ok = 1'b1; asid_in = 8'h5A; tlb_miss = 1'b1;
    #1;
    chk("accept_miss", {67'd0, instMiss}, {67'd0, 1'b1});
    step();
    asid_in = 8'h33;
    #1;
    chk("asid_at_accept", {58'd0, inst_req, asid, instMiss}, {58'd0, 1'b0, 8'h5A, 1'b1});
    chk("exc_type_miss", {36'd0, if_fetch_exc_type}, {36'd0, 32'h2});
    step();
    inst_data_ok = 1'b1;
    #1;
    chk("miss_complete", {35'd0, instValid, if_fetch_exc_type}, {35'd0, 1'b1, 32'h2});
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      chk($sformatf("halted%0d", i), {34'd0, inst_req, instValid, inst_addr}, {34'd0, 2'b00, R});
    end

    // Flush out of the halted state to a misaligned target.
    step();
    flush = 1'b1; flush_pc = 32'h8000_0002;
    #1;
    chk("halt_exc_held", {36'd0, if_fetch_exc_type}, {36'd0, 32'h2});
    step();
    #1;
`ifdef IPF_ADEL_CHECK_EN
    chk("adel_no_req", {2'd0, inst_req, instValid, if_fetch_exc_type, inst_addr},
        {2'd0, 1'b0, 1'b1, 32'h1, 32'h8000_0002});
    step();
    #1;
    chk("adel_halted", {35'd0, inst_req, inst_addr}, {35'd0, 1'b0, 32'h8000_0002});
`else
    chk("unaligned_req", {2'd0, inst_req, instValid, if_fetch_exc_type, inst_addr},
        {2'd0, 1'b1, 1'b0, 32'h0, 32'h8000_0002});
    step();
    inst_addr_ok = 1'b1; inst_data_ok = 1'b1;
    #1;
    chk("unaligned_done", {35'd0, instValid, if_fetch_exc_type}, {35'd0, 1'b1, 32'h0});
    step();
    #1;
    chk("unaligned_next", {35'd0, inst_req, inst_addr}, {35'd0, 1'b1, 32'h8000_0006});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
